// File: rtl/systolic_seq_ctrl.sv
// Sequencing controller for the 4x4 dual-output systolic array: fetches K operand
// tiles per output-tile job, guards each tile with a watchdog, and hands off the result.
module systolic_seq_ctrl #(
  parameter int unsigned TIMEOUT = 31,
  parameter int unsigned KT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [KT_W-1:0] job_ktiles,
  output logic            tile_req,
  input  logic            tile_ack,
  output logic [KT_W-1:0] tile_idx,
  output logic            arr_reset,
  output logic            arr_flush_acc,
  input  logic            arr_done,
  output logic            res_capture,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            err_timeout,
  input  logic            err_clear
);

  localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_START,
    S_RUN,
    S_CAPTURE,
    S_OUT,
    S_ERR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [KT_W-1:0]   kt_q;
  logic [KT_W-1:0]   idx_q;
  logic [WD_W-1:0]   wd_q;
  logic              err_q;
  logic              last_tile;
  logic              wd_expired;

  assign last_tile  = (idx_q == (kt_q - KT_W'(1)));
  assign wd_expired = (wd_q == WD_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done in RUN takes priority over the watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (job_valid) state_d = S_REQ;
      S_REQ:     if (tile_ack) state_d = S_START;
      S_START:   state_d = S_RUN;
      S_RUN: begin
        if (arr_done) begin
          state_d = last_tile ? S_CAPTURE : S_REQ;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_CAPTURE: state_d = S_OUT;
      S_OUT:     if (out_ready) state_d = S_IDLE;
      S_ERR:     if (err_clear) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Job length, tile index, watchdog and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      kt_q  <= KT_W'(1);
      idx_q <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_valid) begin
            kt_q  <= (job_ktiles == '0) ? KT_W'(1) : job_ktiles;
            idx_q <= '0;
          end
        end
        S_START: wd_q <= '0;
        S_RUN: begin
          if (arr_done) begin
            if (!last_tile) idx_q <= idx_q + KT_W'(1);
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_ERR: if (err_clear) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Moore output decode; reset forces the quiescent pattern immediately
  always_comb begin
    job_ready     = 1'b0;
    tile_req      = 1'b0;
    arr_reset     = 1'b0;
    arr_flush_acc = 1'b0;
    res_capture   = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;
    if (reset) begin
      arr_reset = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          job_ready = 1'b1;
          arr_reset = 1'b1;
        end
        S_REQ: begin
          tile_req = 1'b1;
          busy     = 1'b1;
        end
        S_START: begin
          arr_flush_acc = (idx_q == '0);
          busy          = 1'b1;
        end
        S_RUN:     busy = 1'b1;
        S_CAPTURE: begin
          res_capture = 1'b1;
          busy        = 1'b1;
        end
        S_OUT: begin
          out_valid = 1'b1;
          busy      = 1'b1;
        end
        S_ERR: begin
          arr_reset = 1'b1;
          busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tile_idx    = reset ? '0 : idx_q;
  assign err_timeout = err_q & ~reset;

endmodule
